// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : Data-memory access plus MEM/WB pipeline register (8-bit MIPS).
//            Optional macro MEM_RESET_CLEAR_EN clears data memory on reset.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      valid_i,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      MemtoReg,
    input  logic                      RegWrite,
    input  logic [DATA_WIDTH-1:0]     ALUr,
    input  logic [DATA_WIDTH-1:0]     WriteD,
    input  logic [REG_ADDR_WIDTH-1:0] WriteReg,
    output logic                      valid_o,
    output logic                      MemtoReg_o,
    output logic                      RegWrite_o,
    output logic [DATA_WIDTH-1:0]     ALUr_o,
    output logic [DATA_WIDTH-1:0]     ReadD_o,
    output logic [REG_ADDR_WIDTH-1:0] WriteReg_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0]     w_addr;
    logic                      w_act;
    logic                      w_store;
    logic [DATA_WIDTH-1:0]     w_rdata;
    logic                      w_unused_memread;

    logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]     mem_d [DEPTH];

    logic                      valid_q,    valid_d;
    logic                      memtoreg_q, memtoreg_d;
    logic                      regwrite_q, regwrite_d;
    logic [DATA_WIDTH-1:0]     alur_q,     alur_d;
    logic [DATA_WIDTH-1:0]     readd_q,    readd_d;
    logic [REG_ADDR_WIDTH-1:0] writereg_q, writereg_d;

    // Loads read unconditionally, so MemRead carries no information here.
    assign w_unused_memread = MemRead;

    assign w_addr  = ALUr[ADDR_WIDTH-1:0];
    assign w_act   = valid_i & ~flush & ~stall;
    // A store coinciding with reset is dropped even when memory is not reset.
    assign w_store = w_act & MemWrite & rst_n;
    assign w_rdata = mem_q[w_addr];

    always_comb begin
        mem_d = mem_q;
        if (w_store) begin
            mem_d[w_addr] = WriteD;
        end
    end

`ifdef MEM_RESET_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end
`else
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
`endif

    always_comb begin
        valid_d    = valid_q;
        memtoreg_d = memtoreg_q;
        regwrite_d = regwrite_q;
        alur_d     = alur_q;
        readd_d    = readd_q;
        writereg_d = writereg_q;
        // Flush outranks stall: the bubble must enter even while WB holds.
        if (flush) begin
            valid_d    = 1'b0;
            memtoreg_d = 1'b0;
            regwrite_d = 1'b0;
        end else if (!stall) begin
            valid_d    = valid_i;
            memtoreg_d = MemtoReg & valid_i;
            regwrite_d = RegWrite & valid_i;
            alur_d     = ALUr;
            readd_d    = w_rdata;
            writereg_d = WriteReg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            alur_q     <= '0;
            readd_q    <= '0;
            writereg_q <= '0;
        end else begin
            valid_q    <= valid_d;
            memtoreg_q <= memtoreg_d;
            regwrite_q <= regwrite_d;
            alur_q     <= alur_d;
            readd_q    <= readd_d;
            writereg_q <= writereg_d;
        end
    end

    assign valid_o    = valid_q;
    assign MemtoReg_o = memtoreg_q;
    assign RegWrite_o = regwrite_q;
    assign ALUr_o     = alur_q;
    assign ReadD_o    = readd_q;
    assign WriteReg_o = writereg_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// Bench for mem_wb_stage: directed vectors, a spec-level memory/register model
// checked every falling edge, plus literal expectations at key points.
module tb_mem_wb_stage;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0, flush = 1'b0, valid_i = 1'b0;
    logic          MemRead = 1'b0, MemWrite = 1'b0, MemtoReg = 1'b0, RegWrite = 1'b0;
    logic [DW-1:0] ALUr = '0, WriteD = '0;
    logic [RW-1:0] WriteReg = '0;
    logic          valid_o, MemtoReg_o, RegWrite_o;
    logic [DW-1:0] ALUr_o, ReadD_o;
    logic [RW-1:0] WriteReg_o;

    int n_cmp  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    mem_wb_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_i(valid_i),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUr(ALUr), .WriteD(WriteD), .WriteReg(WriteReg),
        .valid_o(valid_o), .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
        .ALUr_o(ALUr_o), .ReadD_o(ReadD_o), .WriteReg_o(WriteReg_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image with per-word "known" flags, expected WB state.
    logic [DW-1:0] mem_m [2**AW];
    logic          known [2**AW];
    logic          e_valid = 1'b0, e_m2r = 1'b0, e_rw = 1'b0, e_rdk = 1'b1;
    logic [DW-1:0] e_alur = '0, e_rd = '0;
    logic [RW-1:0] e_wr = '0;

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mem_m[i] = '0;
            known[i] = 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid <= 1'b0; e_m2r <= 1'b0; e_rw <= 1'b0;
            e_alur  <= '0;   e_rd  <= '0;   e_rdk <= 1'b1; e_wr <= '0;
`ifdef MEM_RESET_CLEAR_EN
            for (int i = 0; i < 2**AW; i++) begin
                mem_m[i] <= '0;
                known[i] <= 1'b1;
            end
`endif
        end else begin
            if (flush) begin
                e_valid <= 1'b0; e_m2r <= 1'b0; e_rw <= 1'b0;
            end else if (!stall) begin
                e_valid <= valid_i;
                e_m2r   <= valid_i && MemtoReg;
                e_rw    <= valid_i && RegWrite;
                e_alur  <= ALUr;
                e_rd    <= mem_m[ALUr % (2**AW)];
                e_rdk   <= known[ALUr % (2**AW)];
                e_wr    <= WriteReg;
            end
            if (valid_i && !flush && !stall && MemWrite) begin
                mem_m[ALUr % (2**AW)] <= WriteD;
                known[ALUr % (2**AW)] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model valid_o",    {31'b0, valid_o},    {31'b0, e_valid});
            chk("model MemtoReg_o", {31'b0, MemtoReg_o}, {31'b0, e_m2r});
            chk("model RegWrite_o", {31'b0, RegWrite_o}, {31'b0, e_rw});
            chk("model ALUr_o",     {24'b0, ALUr_o},     {24'b0, e_alur});
            chk("model WriteReg_o", {27'b0, WriteReg_o}, {27'b0, e_wr});
            if (e_rdk) chk("model ReadD_o", {24'b0, ReadD_o}, {24'b0, e_rd});
        end
    end

    // Apply one instruction for one clock edge; returns 1 time unit after the edge.
    task automatic drv(input logic v, input logic mr, input logic mw, input logic m2r,
                       input logic rw, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                       input logic [RW-1:0] wr, input logic st, input logic fl);
        valid_i = v; MemRead = mr; MemWrite = mw; MemtoReg = m2r; RegWrite = rw;
        ALUr = a; WriteD = wd; WriteReg = wr; stall = st; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid_o", {31'b0, valid_o}, 32'h0);
        chk("reset ALUr_o",  {24'b0, ALUr_o},  32'h0);
        chk("reset ReadD_o", {24'b0, ReadD_o}, 32'h0);
        rst_n = 1'b1;

        // store then back-to-back load of the same word
        drv(1, 0, 1, 0, 0, 8'h05, 8'hA5, 5'd3, 0, 0);
        chk("store valid_o",    {31'b0, valid_o},    32'h1);
        chk("store RegWrite_o", {31'b0, RegWrite_o}, 32'h0);
        drv(1, 1, 0, 1, 1, 8'h05, 8'h00, 5'd7, 0, 0);
        chk("load ReadD_o",     {24'b0, ReadD_o},    32'hA5);
        chk("load MemtoReg_o",  {31'b0, MemtoReg_o}, 32'h1);
        chk("load RegWrite_o",  {31'b0, RegWrite_o}, 32'h1);
        chk("load WriteReg_o",  {27'b0, WriteReg_o}, 32'h7);

        // address wrap: 0x13 aliases word 3
        drv(1, 0, 1, 0, 0, 8'h13, 8'h3C, 5'd0, 0, 0);
        drv(1, 1, 0, 1, 1, 8'h03, 8'h00, 5'd9, 0, 0);
        chk("wrap ReadD_o", {24'b0, ReadD_o}, 32'h3C);

        // stall holds outputs and suppresses store
        drv(1, 0, 1, 0, 0, 8'h02, 8'h55, 5'd0, 0, 0);
        drv(1, 0, 0, 0, 1, 8'h22, 8'h00, 5'd4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 1, 0, 0, 8'h02, 8'h77, 5'd1, 1, 0);
            chk("stall ALUr_o",     {24'b0, ALUr_o},     32'h22);
            chk("stall RegWrite_o", {31'b0, RegWrite_o}, 32'h1);
        end
        drv(1, 1, 0, 1, 1, 8'h02, 8'h00, 5'd2, 0, 0);
        chk("stall store lost", {24'b0, ReadD_o}, 32'h55);

        // flush + stall together, then flush alone with RegWrite
        drv(1, 0, 1, 0, 0, 8'h04, 8'h10, 5'd0, 0, 0);
        drv(1, 0, 1, 0, 1, 8'h04, 8'h99, 5'd6, 1, 1);
        chk("flush+stall valid_o",    {31'b0, valid_o},    32'h0);
        chk("flush+stall RegWrite_o", {31'b0, RegWrite_o}, 32'h0);
        drv(1, 1, 0, 1, 1, 8'h04, 8'h00, 5'd6, 0, 0);
        chk("flush store lost", {24'b0, ReadD_o}, 32'h10);
        drv(1, 0, 0, 0, 1, 8'h0E, 8'h00, 5'd8, 0, 1);
        chk("flush RegWrite_o", {31'b0, RegWrite_o}, 32'h0);
        chk("flush ALUr_o kept", {24'b0, ALUr_o}, 32'h04);

        // simultaneous read/write returns the old word
        drv(1, 0, 1, 0, 0, 8'h06, 8'h11, 5'd0, 0, 0);
        drv(1, 1, 1, 0, 0, 8'h06, 8'h44, 5'd0, 0, 0);
        chk("rd+wr old data", {24'b0, ReadD_o}, 32'h11);
        drv(1, 1, 0, 1, 1, 8'h06, 8'h00, 5'd5, 0, 0);
        chk("rd+wr new data", {24'b0, ReadD_o}, 32'h44);

        // bubble never writes or asserts RegWrite_o
        drv(0, 0, 1, 1, 1, 8'h06, 8'hFF, 5'd5, 0, 0);
        chk("bubble RegWrite_o", {31'b0, RegWrite_o}, 32'h0);
        chk("bubble MemtoReg_o", {31'b0, MemtoReg_o}, 32'h0);
        drv(1, 1, 0, 1, 1, 8'h06, 8'h00, 5'd5, 0, 0);
        chk("bubble store lost", {24'b0, ReadD_o}, 32'h44);

        // asynchronous reset mid-cycle, with a store that must be lost
        drv(1, 1, 0, 1, 1, 8'h05, 8'h00, 5'd7, 0, 0);
        #2;
        valid_i = 1; MemWrite = 1; ALUr = 8'h05; WriteD = 8'hEE;
        rst_n = 1'b0;
        #1;
        chk("async rst valid_o",    {31'b0, valid_o},    32'h0);
        chk("async rst RegWrite_o", {31'b0, RegWrite_o}, 32'h0);
        chk("async rst MemtoReg_o", {31'b0, MemtoReg_o}, 32'h0);
        chk("async rst ALUr_o",     {24'b0, ALUr_o},     32'h0);
        chk("async rst ReadD_o",    {24'b0, ReadD_o},    32'h0);
        chk("async rst WriteReg_o", {27'b0, WriteReg_o}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drv(1, 1, 0, 1, 1, 8'h05, 8'h00, 5'd7, 0, 0);
`ifdef MEM_RESET_CLEAR_EN
        chk("post-reset load", {24'b0, ReadD_o}, 32'h00);
`else
        chk("post-reset load", {24'b0, ReadD_o}, 32'hA5);
`endif
        drv(0, 0, 0, 0, 0, 8'h00, 8'h00, 5'd0, 0, 0);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the 8-bit MIPS pipeline.
- Holds the data memory (register array). Performs stores and loads, then registers ALUr, ReadD, MemtoReg, RegWrite and the destination register for the write-back mux.
- Sits between the EX/MEM register and the write-back select. Its registered ALUr_o, ReadD_o and MemtoReg_o drive that mux directly.

Parameters:
- DATA_WIDTH, 8, width of ALU result, store data and memory word.
- ADDR_WIDTH, 4, data-memory address bits; depth = 2**ADDR_WIDTH words; must be <= DATA_WIDTH.
- REG_ADDR_WIDTH, 5, register-file index width.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold MEM/WB register and suppress store this cycle.
- flush  in  1  replace the instruction in MEM with a bubble.
- valid_i  in  1  instruction in MEM is real (0 = bubble).
- MemRead  in  1  load.
- MemWrite  in  1  store.
- MemtoReg  in  1  write-back selects memory data.
- RegWrite  in  1  instruction writes the register file.
- ALUr  in  DATA_WIDTH  ALU result / effective address.
- WriteD  in  DATA_WIDTH  store data.
- WriteReg  in  REG_ADDR_WIDTH  destination register.
- valid_o  out  1  MEM/WB holds a real instruction.
- MemtoReg_o  out  1  registered MemtoReg.
- RegWrite_o  out  1  registered RegWrite, gated by validity.
- ALUr_o  out  DATA_WIDTH  registered ALU result.
- ReadD_o  out  DATA_WIDTH  registered load data.
- WriteReg_o  out  REG_ADDR_WIDTH  registered destination.

Behaviour:
- **Reset:** one clock; reset is asynchronous and active-low. rst_n=0 immediately forces all outputs to 0: valid_o, MemtoReg_o, RegWrite_o, ALUr_o, ReadD_o and WriteReg_o. This applies mid-operation too, and any store in that cycle is lost. Memory contents are governed by the Optional Feature.
- **Address:** addr = ALUr[ADDR_WIDTH-1:0]; upper bits ignored (wrap-around aliasing, e.g. ALUr=0x13 with ADDR_WIDTH=4 -> word 3).
- **Qualifier:** act = valid_i & ~flush & ~stall.
- **Store:** on rising edge, if act & MemWrite, mem[addr] <= WriteD.
- **Load:** combinational read of mem[addr] captured into ReadD_o at the same edge. Latency 1 cycle from MEM-stage presentation to ReadD_o.
- **Load on non-load:** if MemRead=0, ReadD_o still captures mem[addr]; it is don't-care because MemtoReg_o should be 0.
- **MemRead & MemWrite both 1:** store performed; ReadD_o captures pre-write (old) word.
- **Back-to-back:** a store at edge N followed by a load of the same address presented in the next cycle returns the new data at edge N+1.
- **Register update on each edge:**
  - flush=1 (priority over stall): valid_o<=0, RegWrite_o<=0, MemtoReg_o<=0; other outputs unchanged.
  - else stall=1: all outputs hold; no store.
  - else: valid_o<=valid_i, RegWrite_o<=RegWrite & valid_i, MemtoReg_o<=MemtoReg & valid_i; ALUr_o<=ALUr, ReadD_o<=mem[addr], WriteReg_o<=WriteReg.
- **Bubble:** valid_i=0 never writes memory or asserts RegWrite_o.
- **State machine:** none beyond the register. Two effective states per cycle, LOAD (update) or HOLD (stall), plus bubble injection via flush.

Optional Feature:
- Macro MEM_RESET_CLEAR_EN.
- Defined: rst_n=0 asynchronously clears every memory word to 0.
- Undefined: memory has no reset and retains contents through reset; power-up contents undefined (X in simulation). Only the MEM/WB register is reset.

Test Plan:
- **Reset:** drive rst_n=0 mid-cycle after loading outputs -> all outputs 0 immediately without clock edge. With MEM_RESET_CLEAR_EN, a subsequent load of addr 5 returns 0x00.
- **Store/load:**
  - Store WriteD=0xA5 at ALUr=0x05, valid_i=1 -> valid_o=1, RegWrite_o=0.
  - Next cycle load ALUr=0x05, MemtoReg=1, RegWrite=1, WriteReg=7 -> after 1 edge ReadD_o=0xA5, MemtoReg_o=1, RegWrite_o=1, WriteReg_o=7.
- **Address wrap:** store 0x3C at ALUr=0x13 -> load at ALUr=0x03 returns 0x3C (ADDR_WIDTH=4).
- **Stall:**
  - Outputs hold ALUr_o=0x22 while stall=1 for 3 cycles.
  - Store to addr 2 with 0x77 issued during stall -> mem[2] unchanged (later load returns old value).
- **Flush vs stall:**
  - flush=1 and stall=1 together with a store of 0x99 to addr 4 -> valid_o=0, RegWrite_o=0, mem[4] unchanged.
  - Flush with RegWrite=1 -> RegWrite_o=0.
- **Simultaneous MemRead & MemWrite:** mem[6]=0x11, store 0x44 to addr 6 with MemRead=1 -> ReadD_o=0x11; next load of addr 6 -> 0x44.
